// File: rtl/x4xx_qsfp_chdr_mux_if.sv
// x4xx_qsfp_chdr_mux_if: four CHDR lanes in, one merged CHDR stream out, plus status/stats
interface x4xx_qsfp_chdr_mux_if #(
  parameter int CHDR_W = 64,
  parameter int CNT_W  = 32
);
  logic [4*CHDR_W-1:0] s_tdata;
  logic [3:0]          s_tlast;
  logic [3:0]          s_tvalid;
  logic [3:0]          s_tready;
  logic [CHDR_W-1:0]   m_tdata;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready;
  logic [1:0]          active_lane;
  logic                stats_clr;
  logic [4*CNT_W-1:0]  pkt_count;
  modport slave (
    input  s_tdata, s_tlast, s_tvalid, m_tready, stats_clr,
    output s_tready, m_tdata, m_tlast, m_tvalid, active_lane, pkt_count
  );
  modport master (
    output s_tdata, s_tlast, s_tvalid, m_tready, stats_clr,
    input  s_tready, m_tdata, m_tlast, m_tvalid, active_lane, pkt_count
  );
endinterface

// File: rtl/x4xx_qsfp_chdr_mux.sv
// x4xx_qsfp_chdr_mux: packet-granular 4:1 round-robin CHDR mux (stats via X4XX_QSFP_CHDR_MUX_STATS_EN)
module x4xx_qsfp_chdr_mux #(
  parameter int CHDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst,
  x4xx_qsfp_chdr_mux_if.slave     io
);
  typedef enum logic {IDLE, PASS} state_t;
  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d, last_q, last_d;
  logic [1:0]        off, pick;
  logic [3:0]        rot;
  logic [CHDR_W-1:0] tdata;
  logic              tlast, tvalid;
  logic [3:0]        tready;
  // round-robin pick: rotate valids so last+1 sits at bit 0, then take the lowest set bit
  always_comb begin
    off  = last_q + 2'd1;
    rot  = 4'({io.s_tvalid, io.s_tvalid} >> off);
    pick = off + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  end
  // grant FSM and zero-latency passthrough of the granted lane
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    tdata   = '0;
    tlast   = 1'b0;
    tvalid  = 1'b0;
    tready  = 4'b0;
    if (state_q == IDLE) begin
      if (|io.s_tvalid) begin
        state_d = PASS;
        sel_d   = pick;
        last_d  = pick;
      end
    end else begin
      tdata  = io.s_tdata[sel_q*CHDR_W +: CHDR_W];
      tlast  = io.s_tlast[sel_q];
      tvalid = io.s_tvalid[sel_q];
      tready = 4'(io.m_tready) << sel_q;
      state_d = (tvalid && io.m_tready && tlast) ? IDLE : PASS;
    end
  end
  // state registers; last starts at 3 so lane 0 wins the first arbitration
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end
  assign io.m_tdata     = tdata;
  assign io.m_tlast     = tlast;
  assign io.m_tvalid    = tvalid;
  assign io.s_tready    = tready;
  assign io.active_lane = sel_q;
`ifdef X4XX_QSFP_CHDR_MUX_STATS_EN
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear wins over a coincident tlast handshake
    always_comb begin
      cnt_d = io.stats_clr ? '0 :
              (io.s_tvalid[g] && tready[g] && io.s_tlast[g]) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    // per-lane completed-packet counter, wraps naturally
    always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    assign io.pkt_count[g*CNT_W +: CNT_W] = cnt_q;
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = io.stats_clr;
  assign io.pkt_count     = {4*CNT_W{1'b0}};
`endif
endmodule
